// File: rtl/acc_arb_pkg.sv
// ============================================================================
//  Module      : acc_arb_pkg
//  Description : Opcode and state encodings for the shared accumulator arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package acc_arb_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin pick; search starts just after last.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]         pick,
    output logic [$clog2(N_REQ)-1:0] pick_idx,
    output logic                     any
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        // One extra bit holds last+k before wrapping back into range
        for (int k = 1; k <= N_REQ; k++) begin
            w_sum = {1'b0, last} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N_REQ))
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            w_idx = w_sum[IDX_W-1:0];
            if (!any && req[w_idx]) begin
                any         = 1'b1;
                pick[w_idx] = 1'b1;
                pick_idx    = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/acc_share_arbiter.sv
// ============================================================================
//  Module      : acc_share_arbiter
//  Description : Round-robin sequencer sharing one accumulator among requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_share_arbiter
    import acc_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int EXEC_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [2*N_REQ-1:0]      op_i,
    input  logic [DATA_W*N_REQ-1:0] opnd_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DATA_W-1:0]       acc_o,
    output logic                    ovf_o
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(EXEC_CYC+1);

    if (EXEC_CYC < 1) begin : g_bad_exec_cyc
        $error("acc_share_arbiter: EXEC_CYC must be >= 1");
    end
    if (N_REQ < 2) begin : g_bad_n_req
        $error("acc_share_arbiter: N_REQ must be >= 2");
    end

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_last, r_win;
    logic [1:0]         r_op;
    logic [DATA_W-1:0]  r_opnd, r_acc, w_acc_nxt;
    logic               r_ovf, w_ovf_nxt;
    logic [N_REQ-1:0]   r_gnt, w_pick;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_any, r_busy, r_done;
    logic               w_grant, w_apply, w_finish;
    logic [DATA_W:0]    w_add, w_sub;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req      (req_i),
        .last     (r_last),
        .pick     (w_pick),
        .pick_idx (w_pick_idx),
        .any      (w_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_apply     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: if (w_any) begin
                w_state_nxt = ST_EXEC;
                w_grant     = 1'b1;
            end
            ST_EXEC: if (r_cnt == CNT_W'(EXEC_CYC-1)) begin
                w_state_nxt = ST_DONE;
                w_apply     = 1'b1;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_finish    = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Extra top bit carries the ADD carry-out or the SUB borrow
    always_comb begin
        w_add     = {1'b0, r_acc} + {1'b0, r_opnd};
        w_sub     = {1'b0, r_acc} - {1'b0, r_opnd};
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        case (r_op)
            OP_ADD:   begin w_acc_nxt = w_add[DATA_W-1:0]; w_ovf_nxt = r_ovf | w_add[DATA_W]; end
            OP_SUB:   begin w_acc_nxt = w_sub[DATA_W-1:0]; w_ovf_nxt = r_ovf | w_sub[DATA_W]; end
            OP_LOAD:  w_acc_nxt = r_opnd;
            default:  begin w_acc_nxt = '0; w_ovf_nxt = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_last <= IDX_W'(N_REQ-1);
            r_win  <= '0;
            r_op   <= '0;
            r_opnd <= '0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_gnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_apply;
            if (w_grant) begin
                r_gnt  <= w_pick;
                r_busy <= 1'b1;
                r_win  <= w_pick_idx;
                r_op   <= op_i[2*w_pick_idx +: 2];
                r_opnd <= opnd_i[DATA_W*w_pick_idx +: DATA_W];
                r_cnt  <= '0;
            end else if (r_state == ST_EXEC) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_apply) begin
                r_acc <= w_acc_nxt;
                r_ovf <= w_ovf_nxt;
            end
            if (w_finish) begin
                r_last <= r_win;
                r_gnt  <= '0;
                r_busy <= 1'b0;
            end
        end
    end

    assign gnt_o  = r_gnt;
    assign busy_o = r_busy;
    assign done_o = r_done;
    assign acc_o  = r_acc;
    assign ovf_o  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_acc_share_arbiter.sv
// ============================================================================
//  Module      : tb_acc_share_arbiter
//  Description : Self-checking bench: single-requester vector table plus
//                multi-requester and reset corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_share_arbiter;
    import acc_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_i;
    logic [7:0]  op_i;
    logic [31:0] opnd_i;
    logic [3:0]  gnt_o;
    logic        busy_o, done_o, ovf_o;
    logic [7:0]  acc_o;

    acc_share_arbiter #(.N_REQ(4), .DATA_W(8), .EXEC_CYC(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_i),
        .op_i   (op_i),
        .opnd_i (opnd_i),
        .gnt_o  (gnt_o),
        .busy_o (busy_o),
        .done_o (done_o),
        .acc_o  (acc_o),
        .ovf_o  (ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [1:0] op;
        logic [7:0] opnd;
        logic [7:0] exp_acc;
        logic       exp_ovf;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] acc;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] g, input logic [7:0] a, input logic o);
        exp_t e;
        e.gnt = g; e.acc = a; e.ovf = o;
        return e;
    endfunction

    // Scoreboard: every done pulse consumes one expected completion
    always @(negedge clk) begin
        if (rst === 1'b1 && done_o === 1'b1) begin
            n_done++;
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done with gnt %0h, expected no completion", gnt_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("done_gnt", 32'(gnt_o), 32'(e.gnt));
                check("done_acc", 32'(acc_o), 32'(e.acc));
                check("done_ovf", 32'(ovf_o), 32'(e.ovf));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        req_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t vt[10];
    int   d0;

    initial begin
        vt[0] = '{0, OP_ADD,   8'd5,   8'd5,   1'b0};
        vt[1] = '{1, OP_LOAD,  8'd250, 8'd250, 1'b0};
        vt[2] = '{2, OP_ADD,   8'd10,  8'd4,   1'b1};
        vt[3] = '{3, OP_LOAD,  8'd7,   8'd7,   1'b1};
        vt[4] = '{0, OP_CLEAR, 8'd99,  8'd0,   1'b0};
        vt[5] = '{1, OP_SUB,   8'd1,   8'd255, 1'b1};
        vt[6] = '{2, OP_CLEAR, 8'd0,   8'd0,   1'b0};
        vt[7] = '{3, OP_SUB,   8'd0,   8'd0,   1'b0};
        vt[8] = '{0, OP_ADD,   8'd255, 8'd255, 1'b0};
        vt[9] = '{1, OP_ADD,   8'd1,   8'd0,   1'b1};

        rst = 1'b0; req_i = '0; op_i = '0; opnd_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_gnt",  32'(gnt_o),  0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_acc",  32'(acc_o),  0);
        check("rst_ovf",  32'(ovf_o),  0);

        // Single-requester table; operands scrambled after grant must be ignored
        for (int i = 0; i < 10; i++) begin
            logic [3:0] g;
            g = 4'(1 << vt[i].idx);
            req_i  = g;
            op_i   = 8'($urandom);
            opnd_i = $urandom;
            op_i[2*vt[i].idx +: 2]   = vt[i].op;
            opnd_i[8*vt[i].idx +: 8] = vt[i].opnd;
            q.push_back(mk(g, vt[i].exp_acc, vt[i].exp_ovf));
            @(negedge clk);
            check("c1_gnt",  32'(gnt_o),  32'(g));
            check("c1_busy", 32'(busy_o), 1);
            check("c1_done", 32'(done_o), 0);
            op_i   = 8'($urandom);
            opnd_i = $urandom;
            @(negedge clk);
            check("c2_gnt",  32'(gnt_o),  32'(g));
            check("c2_done", 32'(done_o), 0);
            @(negedge clk);
            check("c3_done", 32'(done_o), 1);
            check("c3_gnt",  32'(gnt_o),  32'(g));
            req_i = '0;
            @(negedge clk);
            check("c4_gnt",  32'(gnt_o),  0);
            check("c4_busy", 32'(busy_o), 0);
        end

        // All four requesters at once: served 0,1,2,3 every 4 cycles
        do_reset();
        d0 = n_done;
        req_i = 4'b1111; op_i = '0; opnd_i = {4{8'd1}};
        for (int k = 0; k < 4; k++) q.push_back(mk(4'(1 << k), 8'(k+1), 1'b0));
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c % 4 == 1) check("all4_gnt", 32'(gnt_o), 32'(1 << (c/4)));
            if (c == 15) check("all4_acc", 32'(acc_o), 4);
            if (done_o) req_i = req_i & ~gnt_o;
        end
        check("all4_dones", n_done - d0, 4);

        // Two held requesters alternate fairly
        do_reset();
        d0 = n_done;
        req_i = 4'b0101; op_i = '0; opnd_i = {4{8'd3}};
        for (int k = 0; k < 6; k++) q.push_back(mk((k % 2) ? 4'b0100 : 4'b0001, 8'(3*(k+1)), 1'b0));
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c % 4 == 1) check("alt_gnt", 32'(gnt_o), ((c/4) % 2) ? 4 : 1);
        end
        req_i = '0;
        repeat (4) @(negedge clk);
        check("alt_gnt_idle", 32'(gnt_o), 0);
        check("alt_acc",      32'(acc_o), 18);
        check("alt_dones",    n_done - d0, 6);

        // Reset in second EXEC cycle aborts with no completion
        d0 = n_done;
        req_i = 4'b0001; op_i = {6'b0, OP_LOAD}; opnd_i = 32'd42;
        @(negedge clk);
        check("abort_gnt", 32'(gnt_o), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_gnt0",  32'(gnt_o),  0);
        check("abort_busy0", 32'(busy_o), 0);
        check("abort_done0", 32'(done_o), 0);
        check("abort_acc0",  32'(acc_o),  0);
        check("abort_ovf0",  32'(ovf_o),  0);
        repeat (2) @(negedge clk);
        req_i = 4'b0011; op_i = '0; opnd_i = {16'd0, 8'd9, 8'd7};
        q.push_back(mk(4'b0001, 8'd7, 1'b0));
        q.push_back(mk(4'b0010, 8'd16, 1'b0));
        rst = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) check("post_rst_gnt0", 32'(gnt_o), 1);
            if (c == 5) check("post_rst_gnt1", 32'(gnt_o), 2);
            if (done_o) req_i = req_i & ~gnt_o;
        end
        check("abort_dones", n_done - d0, 2);
        check("queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
